// File: rtl/tns_pkg.sv
// Shared TNS constants: tribonacci wire weights for the 31-wire crosstalk-avoidance code.
// Wire i carries weight t(i) with t(0..2) = 1, 2, 4 and t(n) = t(n-1) + t(n-2) + t(n-3).
package tns_pkg;

   localparam int unsigned TNS_CW   = 31;
   localparam int unsigned TNS_NGRP = 11;
   localparam int unsigned BLEN11_C = 27;
   localparam int unsigned TNS_SW   = BLEN11_C + 2;

   // Group kk covers wires 3kk-1 (A), 3kk-2 (B), 3kk-3 (C); group 11 is wire 30 alone.
   localparam int unsigned TNS01_C = 32'd1;
   localparam int unsigned TNS01_B = 32'd2;
   localparam int unsigned TNS01_A = 32'd4;
   localparam int unsigned TNS02_C = 32'd7;
   localparam int unsigned TNS02_B = 32'd13;
   localparam int unsigned TNS02_A = 32'd24;
   localparam int unsigned TNS03_C = 32'd44;
   localparam int unsigned TNS03_B = 32'd81;
   localparam int unsigned TNS03_A = 32'd149;
   localparam int unsigned TNS04_C = 32'd274;
   localparam int unsigned TNS04_B = 32'd504;
   localparam int unsigned TNS04_A = 32'd927;
   localparam int unsigned TNS05_C = 32'd1705;
   localparam int unsigned TNS05_B = 32'd3136;
   localparam int unsigned TNS05_A = 32'd5768;
   localparam int unsigned TNS06_C = 32'd10609;
   localparam int unsigned TNS06_B = 32'd19513;
   localparam int unsigned TNS06_A = 32'd35890;
   localparam int unsigned TNS07_C = 32'd66012;
   localparam int unsigned TNS07_B = 32'd121415;
   localparam int unsigned TNS07_A = 32'd223317;
   localparam int unsigned TNS08_C = 32'd410744;
   localparam int unsigned TNS08_B = 32'd755476;
   localparam int unsigned TNS08_A = 32'd1389537;
   localparam int unsigned TNS09_C = 32'd2555757;
   localparam int unsigned TNS09_B = 32'd4700770;
   localparam int unsigned TNS09_A = 32'd8646064;
   localparam int unsigned TNS10_C = 32'd15902591;
   localparam int unsigned TNS10_B = 32'd29249425;
   localparam int unsigned TNS10_A = 32'd53798080;
   localparam int unsigned TNS11_C = 32'd98950096;

   typedef enum logic [1:0] {
      SlotA = 2'd0,
      SlotB = 2'd1,
      SlotC = 2'd2
   } tns_slot_e;

   function automatic int unsigned tns_bit_idx(input int unsigned k, input tns_slot_e slot);
      return 3 * k - 1 - {30'd0, slot};
   endfunction

   function automatic int unsigned tns_pick(input tns_slot_e slot, input int unsigned a,
                                            input int unsigned b, input int unsigned c);
      case (slot)
         SlotA:   return a;
         SlotB:   return b;
         default: return c;
      endcase
   endfunction

   // Group 11 has no A/B wires, so those slots weigh zero.
   function automatic int unsigned tns_weight(input int unsigned k, input tns_slot_e slot);
      case (k)
         1:       return tns_pick(slot, TNS01_A, TNS01_B, TNS01_C);
         2:       return tns_pick(slot, TNS02_A, TNS02_B, TNS02_C);
         3:       return tns_pick(slot, TNS03_A, TNS03_B, TNS03_C);
         4:       return tns_pick(slot, TNS04_A, TNS04_B, TNS04_C);
         5:       return tns_pick(slot, TNS05_A, TNS05_B, TNS05_C);
         6:       return tns_pick(slot, TNS06_A, TNS06_B, TNS06_C);
         7:       return tns_pick(slot, TNS07_A, TNS07_B, TNS07_C);
         8:       return tns_pick(slot, TNS08_A, TNS08_B, TNS08_C);
         9:       return tns_pick(slot, TNS09_A, TNS09_B, TNS09_C);
         10:      return tns_pick(slot, TNS10_A, TNS10_B, TNS10_C);
         11:      return tns_pick(slot, 32'd0, 32'd0, TNS11_C);
         default: return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/tns_group_sum.sv
// Weighted sum of one 3-wire TNS group: bit 2 -> WA, bit 1 -> WB, bit 0 -> WC.
module tns_group_sum #(
   parameter int unsigned SW = 29,
   parameter int unsigned WA = 0,
   parameter int unsigned WB = 0,
   parameter int unsigned WC = 1
) (
   input  logic [2:0]    i_bits,
   output logic [SW-1:0] o_sum
);

   localparam logic [SW-1:0] LpWa = SW'(WA);
   localparam logic [SW-1:0] LpWb = SW'(WB);
   localparam logic [SW-1:0] LpWc = SW'(WC);

   always_comb begin
      o_sum = '0;
      if (i_bits[2]) o_sum = o_sum + LpWa;
      if (i_bits[1]) o_sum = o_sum + LpWb;
      if (i_bits[0]) o_sum = o_sum + LpWc;
   end

endmodule

// File: rtl/tns_decoder_31.sv
// 31-wire TNS decoder: group partial sums in stage 1, final sum and overflow flag in stage 2,
// with valid/ready backpressure through both stages.
module tns_decoder_31
   import tns_pkg::*;
#(
   parameter int unsigned CW = TNS_CW,
   parameter int unsigned DW = BLEN11_C
) (
   input  logic          i_clock,
   input  logic          i_rst_n,
   input  logic [CW-1:0] i_codein,
   input  logic          i_in_valid,
   output logic          o_in_ready,
   output logic [DW-1:0] o_dataout,
   output logic          o_code_err,
   output logic          o_out_valid,
   input  logic          i_out_ready
);

   localparam int unsigned SW   = DW + 2;
   localparam int unsigned NGRP = TNS_NGRP;

   logic [SW-1:0] w_part [NGRP];
   logic [SW-1:0] r_part [NGRP];
   logic          r_s1_valid;
   logic [SW-1:0] w_total;
   logic          w_s1_load;
   logic          w_s2_load;
   logic [DW-1:0] r_dataout;
   logic          r_code_err;
   logic          r_out_valid;

   for (genvar g = 0; g < NGRP; g++) begin : g_grp
      localparam int unsigned K = g + 1;
      logic [2:0] w_bits;

      if (K == NGRP) begin : g_last
         assign w_bits = {2'b00, i_codein[tns_bit_idx(K, SlotC)]};
      end else begin : g_full
         assign w_bits = {i_codein[tns_bit_idx(K, SlotA)],
                          i_codein[tns_bit_idx(K, SlotB)],
                          i_codein[tns_bit_idx(K, SlotC)]};
      end

      tns_group_sum #(
         .SW (SW),
         .WA (tns_weight(K, SlotA)),
         .WB (tns_weight(K, SlotB)),
         .WC (tns_weight(K, SlotC))
      ) u_sum (
         .i_bits (w_bits),
         .o_sum  (w_part[g])
      );
   end

   // in_ready depends combinationally on out_ready so a full pipe still streams.
   assign w_s2_load  = !r_out_valid || i_out_ready;
   assign w_s1_load  = !r_s1_valid || w_s2_load;
   assign o_in_ready = w_s1_load;

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1_valid <= 1'b0;
         for (int unsigned g = 0; g < NGRP; g++) r_part[g] <= '0;
      end else if (w_s1_load) begin
         r_s1_valid <= i_in_valid;
         if (i_in_valid) begin
            for (int unsigned g = 0; g < NGRP; g++) r_part[g] <= w_part[g];
         end
      end
   end

   // DW+2 bits hold the all-ones codeword sum, so nothing is lost before the overflow test.
   always_comb begin
      w_total = '0;
      for (int unsigned g = 0; g < NGRP; g++) w_total = w_total + r_part[g];
   end

   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_valid <= 1'b0;
         r_dataout   <= '0;
         r_code_err  <= 1'b0;
      end else if (w_s2_load) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_dataout  <= w_total[DW-1:0];
            r_code_err <= |w_total[SW-1:DW];
         end
      end
   end

   assign o_dataout   = r_dataout;
   assign o_code_err  = r_code_err;
   assign o_out_valid = r_out_valid;

endmodule

// File: doc/tns_decoder_31.md
Name: tns_decoder_31

Overview:
Receive-side counterpart of the 31-wire TNS crosstalk-avoidance encoder. It takes a registered 31-bit TNS codeword from the link and reconstructs the binary data word. Reconstruction is a weighted sum of codeword bits using the shared TNS weight constants. The block is a 2-stage valid/ready pipeline with backpressure and an overflow/illegal-code flag, placed directly after the link capture register.

Parameters:
CW, 31, codeword width (fixed; other values unsupported)
DW, `BLEN11_C, decoded data width (from shared TNS header)

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
codein  in  CW  TNS codeword; bit 30 is MSB weight
in_valid  in  1  codein valid this cycle
in_ready  out  1  decoder can accept codein this cycle
dataout  out  DW  decoded data word
code_err  out  1  decoded sum does not fit in DW bits; qualified by out_valid
out_valid  out  1  dataout/code_err valid
out_ready  in  1  downstream accepts dataout

Behaviour:
- Interface: one clock, `clock`. Reset `rst_n` is asynchronous, active-low. All flops clear on assertion.
- Reset values: dataout=0, code_err=0, out_valid=0, internal stage valid=0, partial-sum registers=0. in_ready=1 once reset is released.
- Weight map: bit30 -> TNS11_C.
- Groups k=10..2: bit 3k-1 -> TNSk_A, bit 3k-2 -> TNSk_B, bit 3k-3 -> TNSk_C.
- Group 1: bit2 -> TNS01_A, bit1 -> TNS01_B, bit0 -> weight 1.
- Arithmetic: every partial and final sum is unsigned, DW+2 bits wide, with no truncation before the overflow check.
- Stage 1 (S1), on a transfer (in_valid & in_ready):
  - Compute 11 group partial sums (group 11 = bit30 only).
  - Register them with s1_valid=1.
- Stage 2 (S2):
  - Add the 11 S1 partials.
  - Register dataout = sum[DW-1:0].
  - Register code_err = |sum[DW+1:DW].
  - Set out_valid=1.
- Latency: 2 cycles from the input transfer to out_valid. Throughput is 1 word/cycle when out_ready=1.
- Pipeline advance rule:
  - S2 loads when (!out_valid | out_ready).
  - S1 loads when (!s1_valid | S2 loads).
  - in_ready = (!s1_valid | S2 loads). This is combinational from out_ready, which is allowed.
- Stall: with out_valid=1 and out_ready=0, dataout/code_err/out_valid hold stable. S1 holds one more word, then in_ready=0. No word is dropped or duplicated.
- Bubbles: in_valid=0 with S1 advancing sets s1_valid=0. S2 loads out_valid=0 when it advances with s1_valid=0.
- Simultaneous events: in the same cycle, S2 may accept from S1 and S1 may accept new codein. Ordering is strictly FIFO.
- code_err: the word still passes downstream, with dataout holding the truncated low DW bits. The decoder keeps no internal error state, so the flag is per-word only.
- Stateless decode: unlike the encoder, no dependency on the previous codeword. The ambiguous first bit of a group is fully determined by its weight.
- Reset mid-operation: all in-flight words are discarded and out_valid drops asynchronously. After release, the first output is the first word accepted after release.

Decomposition:
- Shared TNS header (existing TNS.vh): BLEN11_C, TNSkk_A/B/C weights, RLENkk widths. Add TNS_CW=31 and a group-bit-index macro if missing. No local copies of weights.
- Sub-module tns_group_sum:
  - Inputs: 3 code bits, three weight parameters.
  - Output: DW+2-bit partial sum.
  - Instantiated 11 times; group 11 with only the C weight nonzero, group 1 with the C weight = 1.

Test Plan:
- Reset, then codein=0, in_valid=1, out_ready=1 -> out_valid rises 2 cycles after the transfer with dataout=0 and code_err=0; in_ready=1 throughout.
- Single-bit codewords 31'h1, then 31'h2, 31'h4, 31'h4000_0000 -> dataout = 1, TNS01_B, TNS01_A, TNS11_C, one per cycle in order.
- Closed-loop round trip through the TNS encoder: 10k random datain values, codeout fed to codein every cycle, ready tied high -> dataout equals datain delayed 1+2 cycles; code_err never 1.
- Backpressure: stream 8 words, out_ready=0 for 3 cycles from the second output -> dataout holds; in_ready drops once S1 is full; all 8 words emerge once in order.
- Overflow: codein=31'h7FFF_FFFF (sum of all weights) -> code_err=1 when the sum ≥ 2^DW, otherwise 0, matching the golden model; word still delivered.
- Reset mid-stream: assert rst_n=0 with 2 words in flight -> out_valid=0 immediately. After release, the next output corresponds to the first post-reset input.
